// File: rtl/riscv_pkg.sv
// Shared core definitions: control-transfer opcodes, branch funct3 codes and
// the redirect FSM state type.
package riscv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_cond.sv
// Pure combinational branch-condition decode from ALU subtract flags.
// funct3 010/011 have no branch meaning and report illegal, never taken.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       carry,
    input  logic       overflow,
    input  logic       sign,
    output logic       taken,
    output logic       illegal
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = sign ^ overflow;
            F3_BGE:  taken = ~(sign ^ overflow);
            F3_BLTU: taken = ~carry;
            F3_BGEU: taken = carry;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_redirect.sv
// EX-stage branch/jump resolution: registered PC redirect, link write-back,
// and a FLUSH_CYCLES-long pipeline flush that squashes wrong-path work.
module branch_redirect
    import riscv_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             stall,
    input  logic [6:0]       ex_opcode,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             zero_flag,
    input  logic             carry_alu,
    input  logic             overflow_alu,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             link_valid,
    output logic [XLEN-1:0]  link_data,
    output logic             misalign_err,
    output logic             illegal_br,
    output logic [CNT_W-1:0] taken_count
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    br_state_e        state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic             link_valid_q, link_valid_d;
    logic [XLEN-1:0]  link_data_q, link_data_d;
    logic             misalign_q, misalign_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic            is_branch, is_jal, is_jalr;
    logic            cond_taken, cond_illegal, taken;
    logic [XLEN-1:0] target;

    branch_cond u_branch_cond (
        .funct3   (ex_funct3),
        .zero     (zero_flag),
        .carry    (carry_alu),
        .overflow (overflow_alu),
        .sign     (alu_result[XLEN-1]),
        .taken    (cond_taken),
        .illegal  (cond_illegal)
    );

    assign is_branch = (ex_opcode == OP_BRANCH);
    assign is_jal    = (ex_opcode == OP_JAL);
    assign is_jalr   = (ex_opcode == OP_JALR);
    assign taken     = (is_branch & cond_taken) | is_jal | is_jalr;
    assign target    = is_jalr ? (alu_result & ~XLEN'(1)) : (ex_pc + ex_imm);

    always_comb begin
        state_d          = state_q;
        fcnt_d           = fcnt_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        link_valid_d     = link_valid_q;
        link_data_d      = link_data_q;
        misalign_d       = misalign_q;
        illegal_d        = illegal_q;
        taken_count_d    = taken_count_q;

        // Stall leaves every register at its current value, pulses included.
        if (!stall) begin
            redirect_valid_d = 1'b0;
            link_valid_d     = 1'b0;
            misalign_d       = 1'b0;
            illegal_d        = 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        illegal_d = is_branch & cond_illegal;
                        if (taken && target[1]) begin
                            misalign_d = 1'b1;
                        end else if (taken) begin
                            redirect_valid_d = 1'b1;
                            redirect_pc_d    = target;
                            flush_d          = 1'b1;
                            fcnt_d           = FC_W'(FLUSH_CYCLES);
                            state_d          = FLUSH;
                            if (is_jal || is_jalr) begin
                                link_valid_d = 1'b1;
                                link_data_d  = ex_pc + XLEN'(4);
                            end
                            if (taken_count_q != '1) begin
                                taken_count_d = taken_count_q + CNT_W'(1);
                            end
                        end
                    end
                end
                FLUSH: begin
                    // EX contents are wrong-path here; only the countdown runs.
                    fcnt_d = fcnt_q - FC_W'(1);
                    if (fcnt_q == FC_W'(1)) begin
                        flush_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            fcnt_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            link_valid_q     <= 1'b0;
            link_data_q      <= '0;
            misalign_q       <= 1'b0;
            illegal_q        <= 1'b0;
            taken_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            link_valid_q     <= link_valid_d;
            link_data_q      <= link_data_d;
            misalign_q       <= misalign_d;
            illegal_q        <= illegal_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if_id    = flush_q;
    assign flush_id_ex    = flush_q;
    assign link_valid     = link_valid_q;
    assign link_data      = link_data_q;
    assign misalign_err   = misalign_q;
    assign illegal_br     = illegal_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect: a table of single-instruction vectors
// followed by hand sequences for back-to-back, stall and mid-flush reset.
module tb_branch_redirect;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, stall;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [63:0] ex_pc, ex_imm, alu_result;
    logic        zero_flag, carry_alu, overflow_alu;
    logic        redirect_valid, flush_if_id, flush_id_ex, link_valid;
    logic        misalign_err, illegal_br;
    logic [63:0] redirect_pc, link_data;
    logic [31:0] taken_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_redirect #(.XLEN(64), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .stall          (stall),
        .ex_opcode      (ex_opcode),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .alu_result     (alu_result),
        .zero_flag      (zero_flag),
        .carry_alu      (carry_alu),
        .overflow_alu   (overflow_alu),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .link_valid     (link_valid),
        .link_data      (link_data),
        .misalign_err   (misalign_err),
        .illegal_br     (illegal_br),
        .taken_count    (taken_count)
    );

    typedef struct {
        logic        valid;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] pc, imm, alu;
        logic        z, c, v;
        logic        e_red;
        logic [63:0] e_pc;
        logic        e_link;
        logic [63:0] e_ld;
        logic        e_mis, e_ill;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        ex_valid     = t.valid;
        ex_opcode    = t.op;
        ex_funct3    = t.f3;
        ex_pc        = t.pc;
        ex_imm       = t.imm;
        alu_result   = t.alu;
        zero_flag    = t.z;
        carry_alu    = t.c;
        overflow_alu = t.v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t t;
        int   n;

        //          valid op         f3       pc                     imm                    alu                    z  c  v  red e_pc      link e_ld     mis ill cnt
        vecs[0]  = '{1'b1, OP_BRANCH, F3_BEQ,  64'h1000,              64'h8,                 64'h0,                 1, 0, 0, 1, 64'h1008, 0, 64'h0,    0, 0, 32'd1};
        vecs[1]  = '{1'b1, OP_BRANCH, F3_BEQ,  64'h1000,              64'h8,                 64'h1,                 0, 0, 0, 0, 64'h0,    0, 64'h0,    0, 0, 32'd1};
        vecs[2]  = '{1'b1, OP_BRANCH, F3_BNE,  64'h1000,              64'h8,                 64'h1,                 0, 0, 0, 1, 64'h1008, 0, 64'h0,    0, 0, 32'd2};
        vecs[3]  = '{1'b1, OP_BRANCH, F3_BEQ,  64'h1000,              64'hFFFF_FFFF_FFFF_FFF8, 64'h0,               1, 0, 0, 1, 64'hFF8,  0, 64'h0,    0, 0, 32'd3};
        vecs[4]  = '{1'b1, OP_BRANCH, F3_BEQ,  64'hFFFF_FFFF_FFFF_FFFC, 64'h8,               64'h0,                 1, 0, 0, 1, 64'h4,    0, 64'h0,    0, 0, 32'd4};
        vecs[5]  = '{1'b1, OP_BRANCH, F3_BLT,  64'h1000,              64'h8,                 64'h8000_0000_0000_0000, 0, 0, 1, 0, 64'h0,  0, 64'h0,    0, 0, 32'd4};
        vecs[6]  = '{1'b1, OP_BRANCH, F3_BLTU, 64'h2000,              64'h10,                64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 64'h2010, 0, 64'h0,  0, 0, 32'd5};
        vecs[7]  = '{1'b1, OP_BRANCH, 3'b010,  64'h1000,              64'h8,                 64'h0,                 1, 1, 0, 0, 64'h0,    0, 64'h0,    0, 1, 32'd5};
        vecs[8]  = '{1'b1, OP_JALR,   3'b000,  64'h3000,              64'h0,                 64'h2003,              0, 0, 0, 0, 64'h0,    0, 64'h0,    1, 0, 32'd5};
        vecs[9]  = '{1'b1, OP_JALR,   3'b000,  64'h3000,              64'h0,                 64'h2001,              0, 0, 0, 1, 64'h2000, 1, 64'h3004, 0, 0, 32'd6};
        vecs[10] = '{1'b1, OP_JAL,    3'b000,  64'h4000,              64'h100,               64'h0,                 0, 0, 0, 1, 64'h4100, 1, 64'h4004, 0, 0, 32'd7};
        vecs[11] = '{1'b1, OP_BRANCH, F3_BGE,  64'h1000,              64'h20,                64'h5,                 0, 1, 0, 1, 64'h1020, 0, 64'h0,    0, 0, 32'd8};
        vecs[12] = '{1'b1, OP_BRANCH, F3_BGEU, 64'h1000,              64'h20,                64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 64'h0,  0, 64'h0,    0, 0, 32'd8};
        vecs[13] = '{1'b1, 7'b0110011, 3'b010, 64'h1000,              64'h8,                 64'h0,                 1, 1, 0, 0, 64'h0,    0, 64'h0,    0, 0, 32'd8};
        vecs[14] = '{1'b1, OP_BRANCH, F3_BEQ,  64'h1000,              64'h6,                 64'h0,                 1, 0, 0, 0, 64'h0,    0, 64'h0,    1, 0, 32'd8};
        vecs[15] = '{1'b0, OP_JAL,    3'b000,  64'h1000,              64'h8,                 64'h0,                 1, 0, 0, 0, 64'h0,    0, 64'h0,    0, 0, 32'd8};

        rst_n = 1'b0;
        stall = 1'b0;
        t = vecs[15];
        t.valid = 1'b0;
        drive(t);
        repeat (2) @(posedge clk);
        #1;
        check("reset redirect_valid", 64'(redirect_valid), 64'd0);
        check("reset redirect_pc", redirect_pc, 64'h0);
        check("reset flush_if_id", 64'(flush_if_id), 64'd0);
        check("reset link_data", link_data, 64'h0);
        check("reset taken_count", 64'(taken_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            tick();
            check($sformatf("v%0d redirect_valid", i), 64'(redirect_valid), 64'(vecs[i].e_red));
            if (vecs[i].e_red) check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_pc);
            check($sformatf("v%0d link_valid", i), 64'(link_valid), 64'(vecs[i].e_link));
            if (vecs[i].e_link) check($sformatf("v%0d link_data", i), link_data, vecs[i].e_ld);
            check($sformatf("v%0d misalign_err", i), 64'(misalign_err), 64'(vecs[i].e_mis));
            check($sformatf("v%0d illegal_br", i), 64'(illegal_br), 64'(vecs[i].e_ill));
            check($sformatf("v%0d flush_if_id", i), 64'(flush_if_id), 64'(vecs[i].e_red));
            check($sformatf("v%0d flush_id_ex", i), 64'(flush_id_ex), 64'(vecs[i].e_red));
            check($sformatf("v%0d taken_count", i), 64'(taken_count), 64'(vecs[i].e_cnt));
            @(negedge clk);
            ex_valid = 1'b0;
            tick();
            check($sformatf("v%0d pulse_end", i),
                  64'({redirect_valid, link_valid, misalign_err, illegal_br}), 64'd0);
            check($sformatf("v%0d flush_2nd", i), 64'(flush_if_id), 64'(vecs[i].e_red));
            tick();
            check($sformatf("v%0d flush_done", i), 64'(flush_if_id | flush_id_ex), 64'd0);
        end

        // Back-to-back taken branches: the second lands in FLUSH and is squashed.
        @(negedge clk);
        drive(vecs[0]);
        tick();
        check("b2b first redirect", 64'(redirect_valid), 64'd1);
        check("b2b first pc", redirect_pc, 64'h1008);
        @(negedge clk);
        ex_pc = 64'h5000;
        tick();
        check("b2b second redirect", 64'(redirect_valid), 64'd0);
        check("b2b flush held", 64'(flush_if_id), 64'd1);
        tick();
        check("b2b no late redirect", 64'(redirect_valid), 64'd0);
        check("b2b flush done", 64'(flush_if_id), 64'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        check("b2b count", 64'(taken_count), 64'd9);
        check("b2b pc kept", redirect_pc, 64'h1008);

        // Stall for three edges inside FLUSH stretches the flush to five cycles.
        t = vecs[2];
        t.pc = 64'h6000;
        t.imm = 64'h40;
        @(negedge clk);
        drive(t);
        tick();
        check("stall redirect", 64'(redirect_valid), 64'd1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (flush_if_id) n++;
            else break;
            if (k == 2) check("stall pulse held", 64'(redirect_valid), 64'd1);
            if (k == 0) begin
                stall    = 1'b1;
                ex_valid = 1'b0;
            end
            if (k == 3) stall = 1'b0;
        end
        check("stall flush length", 64'(n), 64'd5);
        check("stall count", 64'(taken_count), 64'd10);

        // Reset in the middle of FLUSH clears outputs without waiting for an edge.
        @(negedge clk);
        drive(vecs[0]);
        tick();
        check("rst pre flush", 64'(flush_if_id), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst flush_if_id", 64'(flush_if_id), 64'd0);
        check("rst flush_id_ex", 64'(flush_id_ex), 64'd0);
        check("rst redirect_valid", 64'(redirect_valid), 64'd0);
        check("rst redirect_pc", redirect_pc, 64'h0);
        check("rst taken_count", 64'(taken_count), 64'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("rst after redirect", 64'(redirect_valid), 64'd0);
        check("rst after flush", 64'(flush_if_id), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
